mtr_ramp: RTL and testbench



---
 rtl/mtr_pkg.sv | 26 ++
 rtl/mtr_ramp_side.sv | 113 +++++++++++
 rtl/mtr_ramp.sv | 83 ++++++++
 tb/tb_mtr_ramp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mtr_pkg.sv
// Shared types and helpers for the motor ramp block: command type, full-scale
// limit, per-side ramp states and the target clamp.
package mtr_pkg;

  typedef logic signed [10:0] cmd_t;

  localparam cmd_t CMD_MAX      = 11'sd1023;
  // The downstream PWM stage cannot represent -1024, so it is never produced.
  localparam cmd_t CMD_NEG_FULL = 11'sh400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    DWELL = 2'd2
  } ramp_state_t;

  function automatic cmd_t clamp_cmd(input cmd_t value);
    cmd_t result;
    result = value;
    if (value == CMD_NEG_FULL) begin
      result = -CMD_MAX;
    end
    return result;
  endfunction

endpackage

// File: rtl/mtr_ramp_side.sv
// One wheel's ramp: latched target, slew-limited command, direction memory and
// the zero-dwell that must elapse before the command may change sign.
module mtr_ramp_side
  import mtr_pkg::*;
#(
  parameter int STEP      = 8,
  parameter int REV_DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic estop,
  input  logic tgt_vld,
  input  cmd_t tgt_req,
  output cmd_t cur,
  output cmd_t tgt
);

  localparam int DW = (REV_DWELL < 2) ? 1 : $clog2(REV_DWELL + 1);
  localparam logic signed [11:0] STEP_W = 12'(STEP);
  localparam cmd_t               STEP_C = 11'(STEP);

  ramp_state_t       state;
  logic [DW-1:0]     dwell;
  logic              last_dir;

  logic              opposing;
  cmd_t              eff_tgt;
  logic signed [11:0] eff_ext;
  logic signed [11:0] cur_ext;
  logic signed [11:0] diff;
  logic signed [11:0] mag;
  cmd_t              step_val;
  logic              tgt_nz;
  logic              same_dir;

  // A target of the opposite sign only pulls the command down to zero; the
  // sign change itself has to go through the dwell.
  always_comb begin
    opposing = (cur != '0) && (tgt != '0) && (cur[10] != tgt[10]);
    eff_tgt  = opposing ? '0 : tgt;
    eff_ext  = {eff_tgt[10], eff_tgt};
    cur_ext  = {cur[10], cur};
    diff     = eff_ext - cur_ext;
    mag      = diff[11] ? -diff : diff;
    step_val = eff_tgt;
    if (mag > STEP_W) begin
      step_val = diff[11] ? (cur - STEP_C) : (cur + STEP_C);
    end
    tgt_nz   = (tgt != '0);
    same_dir = (tgt[10] == last_dir);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      tgt      <= '0;
      state    <= IDLE;
      dwell    <= '0;
      last_dir <= 1'b0;
    end else if (estop) begin
      cur      <= '0;
      tgt      <= '0;
      state    <= IDLE;
      dwell    <= '0;
    end else begin
      if (tgt_vld) begin
        tgt <= clamp_cmd(tgt_req);
      end
      // The step below reads the old tgt, so a coincident request waits a tick.
      if (tick) begin
        case (state)
          IDLE: begin
            if (tgt_nz && (same_dir || (dwell == '0))) begin
              state    <= RAMP;
              cur      <= step_val;
              last_dir <= step_val[10];
            end
          end
          RAMP: begin
            cur <= step_val;
            if (step_val != '0) begin
              last_dir <= step_val[10];
            end else if (cur != '0) begin
              state <= DWELL;
              dwell <= DW'(REV_DWELL);
            end else begin
              state <= IDLE;
            end
          end
          DWELL: begin
            if (tgt_nz && same_dir) begin
              state    <= RAMP;
              cur      <= step_val;
              last_dir <= step_val[10];
              dwell    <= '0;
            end else if (dwell <= DW'(1)) begin
              state <= IDLE;
              dwell <= '0;
            end else begin
              dwell <= dwell - DW'(1);
            end
          end
          default: begin
            state <= IDLE;
            dwell <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/mtr_ramp.sv
// Motor command ramp: shared tick divider feeding two slew-limited sides, with
// emergency stop and a registered both-sides-settled flag.
module mtr_ramp
  import mtr_pkg::*;
#(
  parameter int TICK_DIV  = 500,
  parameter int STEP      = 8,
  parameter int REV_DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] lft_tgt,
  input  logic [10:0] rht_tgt,
  input  logic        tgt_vld,
  input  logic        estop,
  output logic [10:0] lft,
  output logic [10:0] rht,
  output logic        at_tgt
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] tick_cnt;
  logic          tick;
  cmd_t          lft_cur;
  cmd_t          rht_cur;
  cmd_t          lft_tgt_q;
  cmd_t          rht_tgt_q;

  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  // Free-running so the ramp cadence stays fixed regardless of estop or requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  mtr_ramp_side #(
    .STEP      (STEP),
    .REV_DWELL (REV_DWELL)
  ) u_lft (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .estop   (estop),
    .tgt_vld (tgt_vld),
    .tgt_req (cmd_t'(lft_tgt)),
    .cur     (lft_cur),
    .tgt     (lft_tgt_q)
  );

  mtr_ramp_side #(
    .STEP      (STEP),
    .REV_DWELL (REV_DWELL)
  ) u_rht (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .estop   (estop),
    .tgt_vld (tgt_vld),
    .tgt_req (cmd_t'(rht_tgt)),
    .cur     (rht_cur),
    .tgt     (rht_tgt_q)
  );

  assign lft = lft_cur;
  assign rht = rht_cur;

  // Compares the already-registered commands, so it trails each update by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      at_tgt <= 1'b1;
    end else begin
      at_tgt <= (lft_cur == lft_tgt_q) && (rht_cur == rht_tgt_q);
    end
  end

endmodule

// File: tb/tb_mtr_ramp.sv
// Directed bench for mtr_ramp with a short tick so ramps, dwells, clamp,
// estop and asynchronous reset can all be walked through tick by tick.
module tb_mtr_ramp;

  localparam int TICK_DIV  = 4;
  localparam int STEP      = 8;
  localparam int REV_DWELL = 2;

  logic        clk;
  logic        rst_n;
  logic [10:0] lft_tgt;
  logic [10:0] rht_tgt;
  logic        tgt_vld;
  logic        estop;
  logic [10:0] lft;
  logic [10:0] rht;
  logic        at_tgt;

  int checks;
  int failures;
  int tb_cnt;

  typedef struct {
    bit vld;
    int lt;
    int rt;
    int el;
    int er;
    bit at_tick;
    bit at_after;
  } vec_t;

  vec_t rows [18];

  mtr_ramp #(
    .TICK_DIV  (TICK_DIV),
    .STEP      (STEP),
    .REV_DWELL (REV_DWELL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lft_tgt (lft_tgt),
    .rht_tgt (rht_tgt),
    .tgt_vld (tgt_vld),
    .estop   (estop),
    .lft     (lft),
    .rht     (rht),
    .at_tgt  (at_tgt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side tick phase so waits land exactly on ramp ticks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 0;
    else        tb_cnt <= (tb_cnt == TICK_DIV - 1) ? 0 : tb_cnt + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic pulse_tgt(input int l, input int r);
    lft_tgt = 11'(l);
    rht_tgt = 11'(r);
    tgt_vld = 1'b1;
    @(posedge clk);
    #1;
    tgt_vld = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.vld) pulse_tgt(v.lt, v.rt);
  endtask

  task automatic wait_tick();
    int c;
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4 * TICK_DIV; i++) begin
      c = tb_cnt;
      @(posedge clk);
      #1;
      if (c == TICK_DIV - 1) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_tick: got timeout expected tick");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int prev;
    int now;
    int n;
    int saw400;
    int jumped;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    lft_tgt  = '0;
    rht_tgt  = '0;
    tgt_vld  = 1'b0;
    estop    = 1'b0;

    rows[0]  = '{1'b1,  20,  5,   8,  5, 1'b0, 1'b0};
    rows[1]  = '{1'b0,   0,  0,  16,  5, 1'b0, 1'b0};
    rows[2]  = '{1'b0,   0,  0,  20,  5, 1'b0, 1'b1};
    rows[3]  = '{1'b1,  12,  5,  12,  5, 1'b0, 1'b1};
    rows[4]  = '{1'b1, -10,  5,   4,  5, 1'b0, 1'b0};
    rows[5]  = '{1'b0,   0,  0,   0,  5, 1'b0, 1'b0};
    rows[6]  = '{1'b0,   0,  0,   0,  5, 1'b0, 1'b0};
    rows[7]  = '{1'b0,   0,  0,   0,  5, 1'b0, 1'b0};
    rows[8]  = '{1'b0,   0,  0,  -8,  5, 1'b0, 1'b0};
    rows[9]  = '{1'b0,   0,  0, -10,  5, 1'b0, 1'b1};
    rows[10] = '{1'b1,   0,  5,  -2,  5, 1'b0, 1'b0};
    rows[11] = '{1'b0,   0,  0,   0,  5, 1'b0, 1'b1};
    rows[12] = '{1'b0,   0,  0,   0,  5, 1'b1, 1'b1};
    rows[13] = '{1'b1,  -6,  5,  -6,  5, 1'b0, 1'b1};
    rows[14] = '{1'b1,   6, -3,   0,  0, 1'b0, 1'b0};
    rows[15] = '{1'b0,   0,  0,   0,  0, 1'b0, 1'b0};
    rows[16] = '{1'b0,   0,  0,   0,  0, 1'b0, 1'b0};
    rows[17] = '{1'b0,   0,  0,   6, -3, 1'b0, 1'b1};

    #12;
    checkOutput("reset_lft", $signed(lft), 0);
    checkOutput("reset_rht", $signed(rht), 0);
    checkOutput("reset_at_tgt", int'(at_tgt), 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(rows[i]);
      wait_tick();
      checkOutput($sformatf("row%0d_lft", i), $signed(lft), rows[i].el);
      checkOutput($sformatf("row%0d_rht", i), $signed(rht), rows[i].er);
      checkOutput($sformatf("row%0d_at_tick", i), int'(at_tgt), int'(rows[i].at_tick));
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d_at_after", i), int'(at_tgt), int'(rows[i].at_after));
    end

    // Clamp: -1024 request from +6 goes through zero, dwell, then down to -1023.
    pulse_tgt(-1024, -3);
    prev   = $signed(lft);
    n      = 0;
    saw400 = 0;
    jumped = 0;
    for (int k = 0; k < 200; k++) begin
      wait_tick();
      n++;
      now = $signed(lft);
      if (lft == 11'h400) saw400 = 1;
      if (prev > 0 && now < 0) jumped = 1;
      prev = now;
      if (now == -1023) break;
    end
    checkOutput("clamp_final", $signed(lft), -1023);
    checkOutput("clamp_ticks", n, 131);
    checkOutput("clamp_never_400", saw400, 0);
    checkOutput("clamp_no_sign_jump", jumped, 0);
    @(posedge clk);
    #1;
    checkOutput("clamp_at_tgt", int'(at_tgt), 1);

    // Emergency stop from a ramped state.
    do_reset();
    pulse_tgt(100, -50);
    for (int k = 0; k < 13; k++) wait_tick();
    checkOutput("pre_estop_lft", $signed(lft), 100);
    checkOutput("pre_estop_rht", $signed(rht), -50);
    estop = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("estop_lft", $signed(lft), 0);
    checkOutput("estop_rht", $signed(rht), 0);
    pulse_tgt(30, 30);
    wait_tick();
    wait_tick();
    checkOutput("estop_vld_ignored_lft", $signed(lft), 0);
    checkOutput("estop_vld_ignored_rht", $signed(rht), 0);
    estop = 1'b0;
    wait_tick();
    wait_tick();
    checkOutput("release_hold_lft", $signed(lft), 0);
    checkOutput("release_hold_rht", $signed(rht), 0);
    checkOutput("release_at_tgt", int'(at_tgt), 1);
    pulse_tgt(30, 30);
    wait_tick();
    checkOutput("post_estop_lft", $signed(lft), 8);
    checkOutput("post_estop_rht", $signed(rht), 8);

    // Asynchronous reset in the middle of a ramp.
    pulse_tgt(100, 100);
    for (int k = 0; k < 4; k++) wait_tick();
    checkOutput("midramp_lft", $signed(lft), 40);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_lft", $signed(lft), 0);
    checkOutput("async_reset_rht", $signed(rht), 0);
    checkOutput("async_reset_at_tgt", int'(at_tgt), 1);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_tgt(-16, -16);
    wait_tick();
    checkOutput("after_reset_lft_1", $signed(lft), -8);
    checkOutput("after_reset_rht_1", $signed(rht), -8);
    wait_tick();
    checkOutput("after_reset_lft_2", $signed(lft), -16);
    @(posedge clk);
    #1;
    checkOutput("after_reset_at_tgt", int'(at_tgt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
